// File: rtl/cdc_pkt_pkg.sv
// Shared frame definitions for the write-side packetizer: FSM encoding, frame layout, config checks.
// Frame = one length header word, the payload, then one XOR trailer word when the checksum build is selected.
package cdc_pkt_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2,
      TRAILER = 2'd3
   } state_t;

   // Header word carries the payload length; trailer word is the XOR of all payload words.
   localparam int HDR_WORDS = 1;
`ifdef CDC_PKT_CHECKSUM_EN
   localparam int TRL_WORDS = 1;
`else
   localparam int TRL_WORDS = 0;
`endif

   function automatic int frame_words(input int payload_len);
      return payload_len + HDR_WORDS + TRL_WORDS;
   endfunction

   function automatic bit len_width_ok(input int len_width, input int max_len, input int data_width);
      return (max_len >= 1) && (max_len < (2 ** len_width)) && (max_len <= (2 ** data_width) - 1);
   endfunction

   function automatic int buf_addr_width(input int max_len);
      return (max_len > 1) ? $clog2(max_len) : 1;
   endfunction

endpackage

// File: rtl/cdc_fifo_write_packetizer_if.sv
// Upstream stream plus FIFO write port of the packetizer.
// master = environment side (source of words, FIFO full flag); slave = packetizer side.
interface cdc_fifo_write_packetizer_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_last;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] fifo_write_data;
   logic                  fifo_write_enable;
   logic                  fifo_write_full;

   modport master (
      output in_data, in_valid, in_last, fifo_write_full,
      input  in_ready, fifo_write_data, fifo_write_enable
   );

   modport slave (
      input  in_data, in_valid, in_last, fifo_write_full,
      output in_ready, fifo_write_data, fifo_write_enable
   );
endinterface

// File: rtl/cdc_pkt_buffer.sv
// Payload holding buffer: MAX_LEN words, synchronous write port, combinational read port.
// Contents are not reset; the packetizer only reads entries written in the current packet.
module cdc_pkt_buffer
   import cdc_pkt_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 16,
   parameter int AW         = buf_addr_width(MAX_LEN)
) (
   input  logic                  clock_write,
   input  logic                  write_enable,
   input  logic [AW-1:0]         write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [AW-1:0]         read_addr,
   output logic [DATA_WIDTH-1:0] read_data
);
   logic [DATA_WIDTH-1:0] mem [MAX_LEN];

   always_ff @(posedge clock_write) begin
      if (write_enable) begin
         mem[write_addr] <= write_data;
      end
   end

   assign read_data = mem[read_addr];
endmodule

// File: rtl/cdc_fifo_write_packetizer.sv
// Collects a packet, then writes header(len), payload and optional XOR trailer (CDC_PKT_CHECKSUM_EN) to the FIFO.
// Header is written the cycle after the last accepted word; fifo_write_full stalls emission with data held stable.
module cdc_fifo_write_packetizer
   import cdc_pkt_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 16,
   parameter int LEN_WIDTH  = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clock_write,
   input  logic                  reset,
   cdc_fifo_write_packetizer_if.slave bus,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic                  busy
);
   localparam int AW = buf_addr_width(MAX_LEN);
   localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_LEN);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   if (!len_width_ok(LEN_WIDTH, MAX_LEN, DATA_WIDTH)) begin : g_bad_cfg
      $error("cdc_fifo_write_packetizer: MAX_LEN does not fit LEN_WIDTH/DATA_WIDTH");
   end

   state_t                state, state_nxt;
   logic [LEN_WIDTH-1:0]  len, len_nxt;
   logic [LEN_WIDTH-1:0]  idx, idx_nxt;
   logic                  pkt_inc;
   logic                  accept;
   logic                  emit;
   logic [DATA_WIDTH-1:0] buf_rd;
   logic [DATA_WIDTH-1:0] wr_data;
`ifdef CDC_PKT_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum;
`endif

   // Handshake outputs are gated by reset so the FIFO and upstream see idle during reset.
   assign bus.in_ready          = (state == COLLECT) && !reset;
   assign emit                  = (state != COLLECT) && !bus.fifo_write_full && !reset;
   assign bus.fifo_write_enable = emit;
   assign bus.fifo_write_data   = reset ? '0 : wr_data;
   assign accept                = bus.in_valid && bus.in_ready;
   assign busy                  = !reset && ((state != COLLECT) || (len != '0));

   cdc_pkt_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_LEN    (MAX_LEN),
      .AW         (AW)
   ) u_buf (
      .clock_write  (clock_write),
      .write_enable (accept),
      .write_addr   (len[AW-1:0]),
      .write_data   (bus.in_data),
      .read_addr    (idx[AW-1:0]),
      .read_data    (buf_rd)
   );

   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      idx_nxt   = idx;
      pkt_inc   = 1'b0;
      wr_data   = '0;
      unique case (state)
         COLLECT: begin
            if (accept) begin
               len_nxt = len + LEN_ONE;
               // A full buffer closes the packet even without in_last.
               if (bus.in_last || (len_nxt == LEN_MAX)) begin
                  state_nxt = HEADER;
               end
            end
         end
         HEADER: begin
            wr_data = DATA_WIDTH'(len);
            if (emit) begin
               idx_nxt   = '0;
               state_nxt = PAYLOAD;
            end
         end
         PAYLOAD: begin
            wr_data = buf_rd;
            if (emit) begin
               idx_nxt = idx + LEN_ONE;
               if (idx == (len - LEN_ONE)) begin
`ifdef CDC_PKT_CHECKSUM_EN
                  state_nxt = TRAILER;
`else
                  state_nxt = COLLECT;
                  len_nxt   = '0;
                  pkt_inc   = 1'b1;
`endif
               end
            end
         end
         TRAILER: begin
`ifdef CDC_PKT_CHECKSUM_EN
            wr_data = checksum;
            if (emit) begin
               state_nxt = COLLECT;
               len_nxt   = '0;
               pkt_inc   = 1'b1;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_write) begin
      if (reset) begin
         state     <= COLLECT;
         len       <= '0;
         idx       <= '0;
         pkt_count <= '0;
      end else begin
         state     <= state_nxt;
         len       <= len_nxt;
         idx       <= idx_nxt;
         pkt_count <= pkt_count + CNT_WIDTH'(pkt_inc);
      end
   end

`ifdef CDC_PKT_CHECKSUM_EN
   always_ff @(posedge clock_write) begin
      if (reset) begin
         checksum <= '0;
      end else if (accept) begin
         checksum <= checksum ^ bus.in_data;
      end else if ((state == TRAILER) && emit) begin
         checksum <= '0;
      end
   end
`endif
endmodule

// File: tb/tb_cdc_fifo_write_packetizer.sv
// Directed bench: per-cycle vector table for framing, stalls, reset and ignored input; scoreboard for the forced-end stream.
module tb_cdc_fifo_write_packetizer;
   import cdc_pkt_pkg::*;

   logic        clock_write = 1'b0;
   logic        reset;
   logic [15:0] pkt_count;
   logic        busy;

   int checks = 0;
   int errors = 0;

   cdc_fifo_write_packetizer_if #(.DATA_WIDTH(8)) bus ();

   cdc_fifo_write_packetizer #(
      .DATA_WIDTH (8),
      .MAX_LEN    (16),
      .LEN_WIDTH  (5),
      .CNT_WIDTH  (16)
   ) dut (
      .clock_write (clock_write),
      .reset       (reset),
      .bus         (bus),
      .pkt_count   (pkt_count),
      .busy        (busy)
   );

   always #5 clock_write = ~clock_write;

   typedef struct {
      logic        rst, vld, last;
      logic [7:0]  dat;
      logic        full;
      logic        rdy, en;
      logic [7:0]  wd;
      logic        bsy;
      logic [15:0] pkt;
   } vec_t;

   vec_t        tbl[$];
   logic [7:0]  sb[$];
   bit          sb_on = 1'b0;
   int          sb_writes = 0;
   logic [7:0]  mon_exp;

   task automatic v(input logic rst, input logic vld, input logic last, input logic [7:0] dat,
                    input logic full, input logic rdy, input logic en, input logic [7:0] wd,
                    input logic bsy, input logic [15:0] pkt);
      vec_t e;
      e.rst = rst; e.vld = vld; e.last = last; e.dat = dat; e.full = full;
      e.rdy = rdy; e.en = en; e.wd = wd; e.bsy = bsy; e.pkt = pkt;
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (row %0d): got %0h expected %0h", name, row, act, exp);
      end
   endtask

   // Scoreboard for the streamed phase: every FIFO write must match the next expected word.
   always @(negedge clock_write) begin
      if (sb_on && bus.fifo_write_enable) begin
         sb_writes++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_write: got %0h expected no write", bus.fifo_write_data);
         end else begin
            mon_exp = sb.pop_front();
            chk("sb_word", sb_writes, 32'(bus.fifo_write_data), 32'(mon_exp));
         end
      end
   end

   initial begin
      bit         done;
      logic [7:0] x;
      int         cyc;

      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = 8'h00; bus.fifo_write_full = 1'b0;

      // Reset state
      @(posedge clock_write);
      @(negedge clock_write);
      chk("rst_in_ready", -1, 32'(bus.in_ready), 32'd0);
      chk("rst_wr_en",    -1, 32'(bus.fifo_write_enable), 32'd0);
      chk("rst_wr_data",  -1, 32'(bus.fifo_write_data), 32'd0);
      chk("rst_busy",     -1, 32'(busy), 32'd0);
      @(posedge clock_write); #1;
      reset = 1'b0;
      @(negedge clock_write);
      chk("rst_pkt_count", -1, 32'(pkt_count), 32'd0);
      chk("idle_in_ready", -1, 32'(bus.in_ready), 32'd1);
      @(posedge clock_write); #1;

      // v(rst, vld, last, dat, full,   rdy, en, wd, busy, pkt)
      // 3-word packet A1 B2 C3
      v(0,1,0,8'hA1,0, 1,0,8'h00,0,0);
      v(0,1,0,8'hB2,0, 1,0,8'h00,1,0);
      v(0,1,1,8'hC3,0, 1,0,8'h00,1,0);
      v(0,0,0,8'h00,0, 0,1,8'h03,1,0);
      v(0,0,0,8'h00,0, 0,1,8'hA1,1,0);
      v(0,0,0,8'h00,0, 0,1,8'hB2,1,0);
      v(0,0,0,8'h00,0, 0,1,8'hC3,1,0);
`ifdef CDC_PKT_CHECKSUM_EN
      v(0,0,0,8'h00,0, 0,1,8'hD0,1,0);
`endif
      // Single-word packet 7F
      v(0,1,1,8'h7F,0, 1,0,8'h00,0,1);
      v(0,0,0,8'h00,0, 0,1,8'h01,1,1);
      v(0,0,0,8'h00,0, 0,1,8'h7F,1,1);
`ifdef CDC_PKT_CHECKSUM_EN
      v(0,0,0,8'h00,0, 0,1,8'h7F,1,1);
`endif
      // in_valid held during emission: 22/33 ignored, 44 accepted when in_ready rises
      v(0,1,1,8'h11,0, 1,0,8'h00,0,2);
      v(0,1,0,8'h22,0, 0,1,8'h01,1,2);
      v(0,1,0,8'h33,0, 0,1,8'h11,1,2);
`ifdef CDC_PKT_CHECKSUM_EN
      v(0,1,0,8'h39,0, 0,1,8'h11,1,2);
`endif
      v(0,1,1,8'h44,0, 1,0,8'h00,0,3);
      v(0,1,0,8'h66,0, 0,1,8'h01,1,3);
      v(0,0,0,8'h00,0, 0,1,8'h44,1,3);
`ifdef CDC_PKT_CHECKSUM_EN
      v(0,0,0,8'h00,0, 0,1,8'h44,1,3);
`endif
      // 4-word packet with 5-cycle full stall on the third payload word
      v(0,1,0,8'h01,0, 1,0,8'h00,0,4);
      v(0,1,0,8'h02,0, 1,0,8'h00,1,4);
      v(0,1,0,8'h03,0, 1,0,8'h00,1,4);
      v(0,1,1,8'h04,0, 1,0,8'h00,1,4);
      v(0,0,0,8'h00,0, 0,1,8'h04,1,4);
      v(0,0,0,8'h00,0, 0,1,8'h01,1,4);
      v(0,0,0,8'h00,0, 0,1,8'h02,1,4);
      for (int k = 0; k < 5; k++) v(0,0,0,8'h00,1, 0,0,8'h03,1,4);
      v(0,0,0,8'h00,0, 0,1,8'h03,1,4);
      v(0,0,0,8'h00,0, 0,1,8'h04,1,4);
`ifdef CDC_PKT_CHECKSUM_EN
      v(0,0,0,8'h00,0, 0,1,8'h04,1,4);
`endif
      // Reset during PAYLOAD idx=2, then a fresh single-word packet
      v(0,1,0,8'h0A,0, 1,0,8'h00,0,5);
      v(0,1,0,8'h0B,0, 1,0,8'h00,1,5);
      v(0,1,0,8'h0C,0, 1,0,8'h00,1,5);
      v(0,1,1,8'h0D,0, 1,0,8'h00,1,5);
      v(0,0,0,8'h00,0, 0,1,8'h04,1,5);
      v(0,0,0,8'h00,0, 0,1,8'h0A,1,5);
      v(0,0,0,8'h00,0, 0,1,8'h0B,1,5);
      v(1,0,0,8'h00,0, 0,0,8'h00,0,5);
      v(0,1,1,8'h55,0, 1,0,8'h00,0,0);
      v(0,0,0,8'h00,0, 0,1,8'h01,1,0);
      v(0,0,0,8'h00,0, 0,1,8'h55,1,0);
`ifdef CDC_PKT_CHECKSUM_EN
      v(0,0,0,8'h00,0, 0,1,8'h55,1,0);
`endif
      v(0,0,0,8'h00,0, 1,0,8'h00,0,1);

      foreach (tbl[r]) begin
         reset = tbl[r].rst;
         bus.in_valid = tbl[r].vld;
         bus.in_last = tbl[r].last;
         bus.in_data = tbl[r].dat;
         bus.fifo_write_full = tbl[r].full;
         @(negedge clock_write);
         chk("in_ready",  r, 32'(bus.in_ready), 32'(tbl[r].rdy));
         chk("wr_enable", r, 32'(bus.fifo_write_enable), 32'(tbl[r].en));
         chk("wr_data",   r, 32'(bus.fifo_write_data), 32'(tbl[r].wd));
         chk("busy",      r, 32'(busy), 32'(tbl[r].bsy));
         chk("pkt_count", r, 32'(pkt_count), 32'(tbl[r].pkt));
         @(posedge clock_write); #1;
      end
      reset = 1'b0;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.fifo_write_full = 1'b0;

      // 20 words, in_last only on the 20th: forced end at 16, then a 4-word frame
      sb.push_back(8'h10);
      x = 8'h00;
      for (int i = 0; i < 16; i++) begin
         sb.push_back(8'(8'h30 + i));
         x = x ^ 8'(8'h30 + i);
      end
`ifdef CDC_PKT_CHECKSUM_EN
      sb.push_back(x);
`endif
      sb.push_back(8'h04);
      x = 8'h00;
      for (int i = 16; i < 20; i++) begin
         sb.push_back(8'(8'h30 + i));
         x = x ^ 8'(8'h30 + i);
      end
`ifdef CDC_PKT_CHECKSUM_EN
      sb.push_back(x);
`endif
      sb_on = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 17) begin
            chk("forced_end_pkt_count", i, 32'(pkt_count), 32'd2);
            chk("forced_end_busy",      i, 32'(busy), 32'd1);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'h30 + i);
         bus.in_last  = (i == 19);
         done = 1'b0;
         for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clock_write);
            if (bus.in_ready) done = 1'b1;
            @(posedge clock_write); #1;
         end
         if (!done) begin
            checks++;
            errors++;
            $display("FAIL stream_accept_timeout: word %0d not accepted, required within 64 cycles", i);
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      cyc = 0;
      do begin
         @(negedge clock_write);
         cyc++;
      end while ((busy || sb.size() != 0) && cyc < 100);
      @(posedge clock_write); #1;
      sb_on = 1'b0;
      chk("stream_drain_left", 0, 32'(sb.size()), 32'd0);
      chk("stream_busy_end",   0, 32'(busy), 32'd0);
      chk("stream_word_count", 0, 32'(sb_writes), 32'(frame_words(16) + frame_words(4)));
      chk("stream_pkt_count",  0, 32'(pkt_count), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
